// File: rtl/conv_encoder_framer.sv
// Rate-1/2 K=4 convolutional encoder with framing (FRAME_LEN data bits + 3 zero tail bits).
// Optional: define CONV_ENC_SCRAMBLE_EN to add an additive x^7+x^4+1 scrambler on data bits.
module conv_encoder_framer #(
  parameter int unsigned FRAME_LEN = 1021,
  parameter logic [3:0]  G0        = 4'b1111,
  parameter logic [3:0]  G1        = 4'b1101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       din_valid,
  input  logic       din,
  output logic       din_ready,
  output logic       dout_valid,
  output logic [1:0] dout,
  output logic       dout_sof,
  output logic       dout_eof,
  input  logic       dout_ready,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
  localparam logic [9:0] LAST_BIT = 10'(FRAME_LEN - 1);

  state_t     state, state_nxt;
  logic [2:0] s;
  logic [9:0] bit_cnt;
  logic [1:0] tail_cnt;
  logic       can_load, data_acc, load, bit_in, scr_bit, start;
  logic [3:0] v;

  assign can_load = !dout_valid || dout_ready;
  assign v        = {bit_in, s};
  assign busy     = (state != IDLE) || (dout_valid && dout_eof);

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    data_acc  = 1'b0;
    load      = 1'b0;
    bit_in    = 1'b0;
    start     = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = DATA;
          start     = 1'b1;
        end
        DATA: begin
          din_ready = can_load;
          data_acc  = din_valid && can_load;
          load      = data_acc;
          bit_in    = din ^ scr_bit;
          if (data_acc && bit_cnt == LAST_BIT) state_nxt = TAIL;
        end
        TAIL: begin
          // tail bit is a constant 0, generated whenever the output slot frees up
          load = can_load;
          if (can_load && tail_cnt == 2'd2) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state      <= IDLE;
      s          <= 3'b000;
      bit_cnt    <= '0;
      tail_cnt   <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      if (rst) dout <= 2'b00;
    end else begin
      state <= state_nxt;
      if (start) begin
        s        <= 3'b000;
        bit_cnt  <= '0;
        tail_cnt <= '0;
      end
      if (load) begin
        s          <= {bit_in, s[2:1]};
        dout_valid <= 1'b1;
        dout       <= {^(v & G0), ^(v & G1)};
        dout_sof   <= data_acc && (bit_cnt == '0);
        dout_eof   <= (state == TAIL) && (tail_cnt == 2'd2);
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (data_acc) bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 10'd1;
      if (state == TAIL && load) tail_cnt <= (tail_cnt == 2'd2) ? 2'd0 : tail_cnt + 2'd1;
    end
  end

`ifdef CONV_ENC_SCRAMBLE_EN
  logic [6:0] lfsr;
  assign scr_bit = lfsr[6] ^ lfsr[3];
  always_ff @(posedge clk) begin
    if (rst || !enable || start) lfsr <= 7'h7F;
    else if (data_acc)           lfsr <= {lfsr[5:0], scr_bit};
  end
`else
  assign scr_bit = 1'b0;
`endif
endmodule

// File: tb/tb_conv_encoder_framer.sv
// Scoreboard bench for conv_encoder_framer: four instances (FRAME_LEN 8, default, 4, 1) on shared inputs.
module tb_conv_encoder_framer;
  logic clk = 1'b0;
  logic rst, enable, din_valid, din, dout_ready;
  logic [3:0]      rdy_a, dv_a, sof_a, eof_a, busy_a;
  logic [3:0][1:0] dout_a;
  logic [1:0]      sel;
  logic            obs_rdy, obs_dv, obs_sof, obs_eof, obs_busy;
  logic [1:0]      obs_dout;

  int   checks = 0, passed = 0, cyc = 0;
  logic [3:0] exp_q[$];
  logic [3:0] log_q[$];
  int         log_cyc[$];
  logic       tx_bits[$];
  bit         mon_en = 1'b0;
  logic [3:0] m_got, m_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  conv_encoder_framer #(.FRAME_LEN(8)) u_f8 (
    .clk(clk), .rst(rst), .enable(enable), .din_valid(din_valid), .din(din),
    .din_ready(rdy_a[0]), .dout_valid(dv_a[0]), .dout(dout_a[0]), .dout_sof(sof_a[0]),
    .dout_eof(eof_a[0]), .dout_ready(dout_ready), .busy(busy_a[0]));
  conv_encoder_framer u_fdef (
    .clk(clk), .rst(rst), .enable(enable), .din_valid(din_valid), .din(din),
    .din_ready(rdy_a[1]), .dout_valid(dv_a[1]), .dout(dout_a[1]), .dout_sof(sof_a[1]),
    .dout_eof(eof_a[1]), .dout_ready(dout_ready), .busy(busy_a[1]));
  conv_encoder_framer #(.FRAME_LEN(4)) u_f4 (
    .clk(clk), .rst(rst), .enable(enable), .din_valid(din_valid), .din(din),
    .din_ready(rdy_a[2]), .dout_valid(dv_a[2]), .dout(dout_a[2]), .dout_sof(sof_a[2]),
    .dout_eof(eof_a[2]), .dout_ready(dout_ready), .busy(busy_a[2]));
  conv_encoder_framer #(.FRAME_LEN(1)) u_f1 (
    .clk(clk), .rst(rst), .enable(enable), .din_valid(din_valid), .din(din),
    .din_ready(rdy_a[3]), .dout_valid(dv_a[3]), .dout(dout_a[3]), .dout_sof(sof_a[3]),
    .dout_eof(eof_a[3]), .dout_ready(dout_ready), .busy(busy_a[3]));

  assign obs_rdy  = rdy_a[sel];
  assign obs_dv   = dv_a[sel];
  assign obs_dout = dout_a[sel];
  assign obs_sof  = sof_a[sel];
  assign obs_eof  = eof_a[sel];
  assign obs_busy = busy_a[sel];

  // Reference encoder: G0 taps b,s2,s1,s0; G1 taps b,s2,s0
  function automatic logic [1:0] enc(input logic b, input logic [2:0] st);
    enc = {b ^ st[2] ^ st[1] ^ st[0], b ^ st[2] ^ st[0]};
  endfunction

  always @(negedge clk) begin
    if (mon_en && obs_dv && dout_ready) begin
      m_got = {obs_dout, obs_sof, obs_eof};
      log_q.push_back(m_got);
      log_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected got=%b expected none", m_got);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_got !== m_exp) $display("FAIL sb_symbol got=%b expected=%b", m_got, m_exp);
        else passed++;
      end
    end
  end

  task automatic run_frame(input int n, input bit with_tail);
    logic [2:0] ms;
    int t;
    ms = 3'b000;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      din_valid = 1'b1;
      din = tx_bits[i];
      t = 0;
      @(negedge clk);
      while (!obs_rdy && t < 100) begin @(negedge clk); t++; end
      if (!obs_rdy) begin
        checks++;
        $display("FAIL din_timeout bit=%0d ready=%b expected 1", i, obs_rdy);
        din_valid = 1'b0;
        return;
      end
      exp_q.push_back({enc(din, ms), (i == 0), 1'b0});
      ms = {din, ms[2:1]};
    end
    @(posedge clk); #1;
    din_valid = 1'b0;
    if (with_tail)
      for (int k = 0; k < 3; k++) begin
        exp_q.push_back({enc(1'b0, ms), 1'b0, (k == 2)});
        ms = {1'b0, ms[2:1]};
      end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    checks++;
    if (exp_q.size() != 0) $display("FAIL %s_drain left=%0d expected 0", name, exp_q.size());
    else passed++;
    exp_q.delete();
  endtask

  task automatic finish_idle(input string name);
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({obs_busy, obs_dv} !== 2'b00) $display("FAIL %s_idle busy,valid=%b expected 00", name, {obs_busy, obs_dv});
    else passed++;
  endtask

  task automatic do_reset(input logic [1:0] s_idx);
    sel = s_idx;
    rst = 1'b1; enable = 1'b0; din_valid = 1'b0; din = 1'b0; dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); log_q.delete(); log_cyc.delete(); tx_bits.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    sel = 2'd0; mon_en = 1'b0;
    rst = 1'b1; enable = 1'b1; din_valid = 1'b1; din = 1'b1; dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rdy_a, dv_a, sof_a, eof_a, busy_a, dout_a} !== 28'h0)
      $display("FAIL reset_values got=%h expected 0", {rdy_a, dv_a, sof_a, eof_a, busy_a, dout_a});
    else passed++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({obs_busy, obs_rdy} !== 2'b00) $display("FAIL reset_idle_cycle busy,ready=%b expected 00", {obs_busy, obs_rdy});
    else passed++;
    @(negedge clk);
    checks++;
    if ({obs_busy, obs_rdy} !== 2'b11) $display("FAIL reset_enter_data busy,ready=%b expected 11", {obs_busy, obs_rdy});
    else passed++;
    din_valid = 1'b0;
  endtask

  task automatic test_impulse();
    logic [1:0] tbl[11];
    tbl = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    do_reset(2'd0);
    tx_bits = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    enable = 1'b1;
    run_frame(8, 1'b1);
    drain("impulse");
    checks++;
    if (log_q.size() != 11) $display("FAIL impulse_count got=%0d expected 11", log_q.size());
    else begin
      passed++;
      for (int k = 0; k < 11; k++) begin
        checks++;
        if (log_q[k] !== {tbl[k], (k == 0), (k == 10)})
          $display("FAIL impulse_sym%0d got=%b expected=%b", k, log_q[k], {tbl[k], (k == 0), (k == 10)});
        else passed++;
      end
    end
    finish_idle("impulse");
  endtask

  task automatic test_tail();
    logic [1:0] tbl[7];
    tbl = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11};
    do_reset(2'd2);
    tx_bits = '{1'b1, 1'b1, 1'b1, 1'b1};
    enable = 1'b1;
    run_frame(4, 1'b1);
    din_valid = 1'b1; din = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (obs_rdy !== 1'b0) $display("FAIL tail_din_ready%0d got=%b expected 0", k, obs_rdy);
      else passed++;
    end
    din_valid = 1'b0;
    drain("tail");
    checks++;
    if (log_q.size() != 7) $display("FAIL tail_count got=%0d expected 7", log_q.size());
    else begin
      passed++;
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (log_q[k][3:2] !== tbl[k]) $display("FAIL tail_sym%0d got=%b expected=%b", k, log_q[k][3:2], tbl[k]);
        else passed++;
      end
    end
    finish_idle("tail");
  endtask

  task automatic test_default_frame();
    int nsof, neof, nnz;
    do_reset(2'd1);
    for (int i = 0; i < 1021; i++) tx_bits.push_back(1'b0);
    enable = 1'b1;
    run_frame(1021, 1'b1);
    drain("default");
    nsof = 0; neof = 0; nnz = 0;
    foreach (log_q[k]) begin
      if (log_q[k][1]) nsof++;
      if (log_q[k][0]) neof++;
      if (log_q[k][3:2] != 2'b00) nnz++;
    end
    checks++;
    if (log_q.size() != 1024 || nsof != 1 || neof != 1 || nnz != 0)
      $display("FAIL default_frame got n=%0d sof=%0d eof=%0d nonzero=%0d expected 1024 1 1 0",
               log_q.size(), nsof, neof, nnz);
    else passed++;
    finish_idle("default");
  endtask

  task automatic test_back_to_back();
    do_reset(2'd3);
    enable = 1'b1;
    tx_bits = '{1'b1};
    run_frame(1, 1'b1);
    run_frame(1, 1'b1);
    drain("b2b");
    checks++;
    if (log_q.size() != 8) $display("FAIL b2b_count got=%0d expected 8", log_q.size());
    else begin
      passed++;
      checks++;
      if (log_cyc[4] - log_cyc[3] != 2) $display("FAIL b2b_eof_to_sof got=%0d expected 2", log_cyc[4] - log_cyc[3]);
      else passed++;
      checks++;
      if (log_cyc[1] - log_cyc[0] != 1) $display("FAIL b2b_data_to_tail got=%0d expected 1", log_cyc[1] - log_cyc[0]);
      else passed++;
    end
    finish_idle("b2b");
  endtask

  task automatic test_backpressure();
    logic [4:0] held;
    do_reset(2'd0);
    for (int i = 0; i < 8; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    enable = 1'b1;
    fork
      run_frame(8, 1'b1);
      begin
        repeat (4) @(posedge clk);
        #1 dout_ready = 1'b0;
        @(negedge clk);
        held = {obs_dv, obs_dout, obs_sof, obs_eof};
        checks++;
        if ({obs_dv, obs_rdy} !== 2'b10) $display("FAIL bp_stall_entry valid,ready=%b expected 10", {obs_dv, obs_rdy});
        else passed++;
        repeat (4) begin
          @(negedge clk);
          checks++;
          if ({obs_dv, obs_dout, obs_sof, obs_eof, obs_rdy} !== {held, 1'b0})
            $display("FAIL bp_hold got=%b expected=%b", {obs_dv, obs_dout, obs_sof, obs_eof, obs_rdy}, {held, 1'b0});
          else passed++;
        end
        @(posedge clk); #1 dout_ready = 1'b1;
      end
    join
    drain("bp");
    finish_idle("bp");
  endtask

  task automatic test_abort();
    do_reset(2'd0);
    tx_bits = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    enable = 1'b1;
    run_frame(5, 1'b0);
    enable = 1'b0; dout_ready = 1'b0;
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({obs_dv, obs_busy, obs_rdy, obs_sof, obs_eof} !== 5'b0)
      $display("FAIL abort_outputs got=%b expected 00000", {obs_dv, obs_busy, obs_rdy, obs_sof, obs_eof});
    else passed++;
    drain("abort_pending");
    log_q.delete();
    enable = 1'b1; dout_ready = 1'b1;
    tx_bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    run_frame(8, 1'b1);
    drain("abort_restart");
    finish_idle("abort");
  endtask

  task automatic test_reset_mid_tail();
    do_reset(2'd0);
    for (int i = 0; i < 8; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    enable = 1'b1;
    run_frame(8, 1'b1);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({obs_rdy, obs_dv, obs_dout, obs_sof, obs_eof, obs_busy} !== 7'b0)
      $display("FAIL rst_mid_tail got=%b expected 0000000", {obs_rdy, obs_dv, obs_dout, obs_sof, obs_eof, obs_busy});
    else passed++;
    exp_q.delete();
    mon_en = 1'b1;
    tx_bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    run_frame(8, 1'b1);
    drain("rst_restart");
    finish_idle("rst_restart");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_tail();
    test_default_frame();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_reset_mid_tail();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
